// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO and its read-side consumers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO-ordered holding buffer; entry 0 is always the head presented downstream.
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DATA_WIDTH + 1
) (
  input  logic             read_clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] entry_reg  [2];
  logic [WIDTH-1:0] entry_next [2];
  logic [1:0]       occ_reg;
  logic [1:0]       occ_next;
  logic [1:0]       wr_idx;
  logic             accept;

  always_comb begin
    entry_next = entry_reg;
    // Slot the incoming word lands in, after any same-cycle pop has shifted the buffer.
    wr_idx     = occ_reg - {1'b0, pop};
    accept     = push && !wr_idx[1];
    if (pop) begin
      entry_next[0] = entry_reg[1];
    end
    if (accept) begin
      entry_next[wr_idx[0]] = push_data;
    end
    occ_next = occ_reg + {1'b0, accept} - {1'b0, pop};
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      occ_reg      <= 2'd0;
    end else begin
      entry_reg <= entry_next;
      occ_reg   <= occ_next;
    end
  end

  assign head_data  = entry_reg[0];
  assign head_valid = (occ_reg != 2'd0);
  assign occupancy  = occ_reg;

endmodule

// File: rtl/fifo_read_streamer.sv
// Read-side FIFO consumer: issues reads, absorbs the FIFO read latency and streams
// words out through a skid buffer with burst-boundary tagging.
module fifo_read_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int BURST_LEN   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   read_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_read_data,
  output logic                   fifo_read_enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic [COUNT_WIDTH-1:0] words_read,
  output logic                   busy
);

  localparam logic [15:0] BURST_MAX = 16'(BURST_LEN - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic                   inflight_reg;
  logic [15:0]            burst_cnt_reg;
  logic [COUNT_WIDTH-1:0] words_read_reg;
  logic [1:0]             occupancy;
  logic [2:0]             pending;
  logic                   pop;
  logic                   push;
  logic                   push_last;
  logic [DATA_WIDTH:0]    head_data;

  assign pop       = out_valid & out_ready;
  assign push      = inflight_reg;
  assign push_last = (burst_cnt_reg == BURST_MAX);
  assign pending   = {1'b0, occupancy} + {2'b00, inflight_reg};

  // Counting a same-cycle pop as free space keeps 1 word/cycle without ever overfilling.
  assign fifo_read_enable = (state_reg == STREAM) && !fifo_empty &&
                            (pending < (3'd2 + {2'b00, pop}));

  stream_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .read_clk  (read_clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_data ({push_last, fifo_read_data}),
    .head_data (head_data),
    .head_valid(out_valid),
    .occupancy (occupancy)
  );

  assign out_last   = head_data[DATA_WIDTH];
  assign out_data   = head_data[DATA_WIDTH-1:0];
  assign words_read = words_read_reg;
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (enable) state_next = STREAM;
      STREAM:  if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_next = STREAM;
        end else if (!inflight_reg && (occupancy == 2'd0)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge read_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      inflight_reg   <= 1'b0;
      burst_cnt_reg  <= 16'd0;
      words_read_reg <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_read_enable;
      if (push) begin
        burst_cnt_reg <= push_last ? 16'd0 : burst_cnt_reg + 16'd1;
      end
      if (pop) begin
        words_read_reg <= words_read_reg + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench: a FIFO model feeds two streamer instances (default and a
// 4-bit counter / 3-word burst variant); a monitor checks every accepted word.
module tb_fifo_read_streamer;

  typedef struct {
    logic [7:0] data;
    int         idx;
  } exp_t;

  logic        read_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic        enable   = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        out_ready  = 1'b0;
  logic [7:0]  fifo_read_data = 8'd0;

  logic        fifo_read_enable, out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [15:0] words_read;
  logic        fifo_read_enable4, out_valid4, out_last4, busy4;
  logic [7:0]  out_data4;
  logic [3:0]  words_read4;

  always #5 read_clk = ~read_clk;

  fifo_read_streamer #(.DATA_WIDTH(8), .BURST_LEN(16), .COUNT_WIDTH(16)) dut (
    .read_clk(read_clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_enable(fifo_read_enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .words_read(words_read), .busy(busy));

  fifo_read_streamer #(.DATA_WIDTH(8), .BURST_LEN(3), .COUNT_WIDTH(4)) dut4 (
    .read_clk(read_clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read_enable(fifo_read_enable4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_last(out_last4), .words_read(words_read4), .busy(busy4));

  int         n_vec = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         pops_seen = 0;
  int         issued_idx = 0;
  int         first_rd = -1;
  int         first_valid = -1;
  int         ready_mode = 0;
  logic       ready_const = 1'b1;
  logic [7:0] fifo_q[$];
  exp_t       exp_q[$];

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock cycle: sample the request at the negedge, model the FIFO's registered read.
  task automatic step();
    bit         rd;
    logic [7:0] w;
    w = 8'd0;
    @(negedge read_clk);
    rd = fifo_read_enable;
    if (fifo_empty) check(!fifo_read_enable, "issue_while_empty", longint'(fifo_read_enable), 0);
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (rd && first_rd < 0) first_rd = cyc;
    if (rd) begin
      if (fifo_q.size() == 0) begin
        check(1'b0, "fifo_underflow", 1, 0);
        rd = 1'b0;
      end else begin
        w = fifo_q.pop_front();
        exp_q.push_back('{data: w, idx: issued_idx});
        issued_idx++;
      end
    end
    @(posedge read_clk);
    #1;
    if (rd) fifo_read_data = w;
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
    out_ready = (ready_mode == 0) ? ready_const : ((cyc % 4 == 0) || (cyc % 4 == 3));
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_q.delete();
    fifo_empty = 1'b1;
    issued_idx = 0;
    first_rd   = -1;
    first_valid = -1;
    ready_mode = 0;
    ready_const = 1'b1;
    repeat (2) @(posedge read_clk);
    #1;
    reset_n   = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic load(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(base + i));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_done(input int max_cyc);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid) && n < max_cyc) begin
      step();
      n++;
    end
    check(n < max_cyc, "drain_timeout", n, max_cyc);
  endtask

  // Monitor: pops the scoreboard on every accepted word.
  initial begin : monitor
    logic       prev_stall;
    logic [7:0] pd;
    logic       pl;
    int         exp_words;
    exp_t       e;
    prev_stall = 1'b0;
    pd = 8'd0;
    pl = 1'b0;
    exp_words = 0;
    forever begin
      @(negedge read_clk);
      if (!reset_n) begin
        exp_q.delete();
        exp_words = 0;
        pops_seen = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check(out_valid === 1'b1 && out_data === pd && out_last === pl,
              "stall_stability", longint'(out_data), longint'(pd));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", longint'(out_data), -1);
        end else begin
          e = exp_q.pop_front();
          check(out_data === e.data, "data", longint'(out_data), longint'(e.data));
          check(out_last === ((e.idx + 1) % 16 == 0), "last_b16", longint'(out_last),
                longint'((e.idx + 1) % 16 == 0));
          check(out_valid4 === 1'b1 && out_data4 === e.data, "data_b3", longint'(out_data4),
                longint'(e.data));
          check(out_last4 === ((e.idx + 1) % 3 == 0), "last_b3", longint'(out_last4),
                longint'((e.idx + 1) % 3 == 0));
          check(words_read === 16'(exp_words), "words_read", longint'(words_read),
                longint'(exp_words % 65536));
          check(words_read4 === 4'(exp_words), "words_read_w4", longint'(words_read4),
                longint'(exp_words % 16));
          $display("pop %0d: data=%0d last=%0d words_read=%0d", exp_words, out_data, out_last,
                   words_read);
        end
        exp_words++;
        pops_seen++;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
    end
  end

  initial begin : stimulus
    int n;
    int p0;

    // Reset state
    do_reset();
    check(out_valid === 1'b0, "rst_out_valid", longint'(out_valid), 0);
    check(fifo_read_enable === 1'b0, "rst_read_enable", longint'(fifo_read_enable), 0);
    check(busy === 1'b0, "rst_busy", longint'(busy), 0);
    check(out_last === 1'b0, "rst_out_last", longint'(out_last), 0);
    check(out_data === 8'd0, "rst_out_data", longint'(out_data), 0);
    check(words_read === 16'd0, "rst_words_read", longint'(words_read), 0);

    // Five words 0..4, latency and throughput
    load(5, 1'b0, 0);
    enable = 1'b1;
    run_done(60);
    check(first_valid - first_rd == 2, "first_latency", first_valid - first_rd, 2);
    check(words_read === 16'd5, "count_5", longint'(words_read), 5);
    check(busy === 1'b1, "busy_stream", longint'(busy), 1);

    // One full burst 1..16
    do_reset();
    load(16, 1'b0, 1);
    enable = 1'b1;
    run_done(80);
    check(words_read === 16'd16, "count_16", longint'(words_read), 16);

    // Backpressure pattern 1,0,0,1 with random data
    do_reset();
    load(20, 1'b1, 0);
    ready_mode = 1;
    enable = 1'b1;
    run_done(300);
    ready_mode = 0;
    check(words_read === 16'd20, "count_20", longint'(words_read), 20);

    // Drop enable after three accepted words, then resume
    do_reset();
    load(10, 1'b0, 100);
    enable = 1'b1;
    n = 0;
    while (pops_seen < 3 && n < 50) begin
      step();
      n++;
    end
    check(n < 50, "wait_3_words", n, 50);
    enable = 1'b0;
    step();
    p0 = pops_seen;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check(busy === 1'b0, "drain_to_idle", longint'(busy), 0);
    check(pops_seen - p0 <= 2, "drain_extra_words", pops_seen - p0, 2);
    check(fifo_q.size() == 10 - pops_seen, "drain_no_loss", fifo_q.size(), 10 - pops_seen);
    enable = 1'b1;
    run_done(80);
    check(pops_seen == 10, "resume_total", pops_seen, 10);
    check(words_read === 16'd10, "count_10", longint'(words_read), 10);

    // Asynchronous reset with two words buffered
    do_reset();
    load(8, 1'b0, 50);
    enable = 1'b1;
    n = 0;
    while (pops_seen < 2 && n < 40) begin
      step();
      n++;
    end
    ready_const = 1'b0;
    out_ready = 1'b0;
    repeat (5) step();
    check(out_valid === 1'b1, "prereset_buffered", longint'(out_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check(out_valid === 1'b0, "async_rst_valid", longint'(out_valid), 0);
    check(words_read === 16'd0, "async_rst_words", longint'(words_read), 0);
    check(fifo_read_enable === 1'b0, "async_rst_read_enable", longint'(fifo_read_enable), 0);
    check(busy === 1'b0, "async_rst_busy", longint'(busy), 0);

    // Counter wrap on the 4-bit instance
    do_reset();
    load(18, 1'b1, 0);
    enable = 1'b1;
    run_done(100);
    check(words_read === 16'd18, "count_18", longint'(words_read), 18);
    check(words_read4 === 4'd2, "wrap_w4", longint'(words_read4), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
